// File: rtl/rand_pkg.sv
// Shared types and helpers for the range-limited random draw block.
package rand_pkg;

  localparam int LFSR_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } rrg_state_t;

  // Smear the MSB of (limit-1) downwards; limit 0 wraps to all ones (full range).
  function automatic logic [31:0] mask_for(input logic [31:0] limit);
    logic [31:0] m;
    m = limit - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/rand_range_gen_range_check.sv
// Combinational compare/fold datapath: masks a raw draw, flags it in range,
// and provides the folded value (cand - limit). No state, no backpressure.
module range_check #(
  parameter int W = 16
) (
  input  logic [W-1:0] raw,
  input  logic [W-1:0] mask,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cand,
  output logic         hit,
  output logic [W-1:0] folded
);

  assign cand   = raw & mask;
  assign hit    = (limit == '0) || (cand < limit);
  assign folded = cand - limit;

endmodule

// File: rtl/rand_range_gen.sv
// Uniform draw in [0, limit) by mask-and-reject on the LFSR low bits.
// Latency 1 + tries (max 1 + MAX_TRIES); result held until rsp_ready, one request at a time.
module rand_range_gen
  import rand_pkg::*;
#(
  parameter int W         = 16,
  parameter int MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] lfsr_state,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W-1:0]      req_limit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_value,
  output logic [3:0]        rsp_tries,
  output logic              rsp_fallback
);

  rrg_state_t state_q, state_d;
  logic [W-1:0] limit_q, limit_d;
  logic [W-1:0] mask_q, mask_d;
  logic [3:0]   tries_q, tries_d;
  logic [W-1:0] rsp_value_q, rsp_value_d;
  logic [3:0]   rsp_tries_q, rsp_tries_d;
  logic         rsp_fallback_q, rsp_fallback_d;

  logic [W-1:0] cand;
  logic [W-1:0] folded;
  logic         hit;
  logic [3:0]   tries_inc;
  logic         unused_lfsr_hi;

  assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:W];

  range_check #(.W(W)) u_range_check (
    .raw    (lfsr_state[W-1:0]),
    .mask   (mask_q),
    .limit  (limit_q),
    .cand   (cand),
    .hit    (hit),
    .folded (folded)
  );

  assign tries_inc = tries_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    limit_d        = limit_q;
    mask_d         = mask_q;
    tries_d        = tries_q;
    rsp_value_d    = rsp_value_q;
    rsp_tries_d    = rsp_tries_q;
    rsp_fallback_d = rsp_fallback_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          limit_d = req_limit;
          mask_d  = W'(mask_for(32'(req_limit)));
          tries_d = 4'd0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        tries_d = tries_inc;
        if (hit) begin
          rsp_value_d    = cand;
          rsp_tries_d    = tries_inc;
          rsp_fallback_d = 1'b0;
          state_d        = HOLD;
        end else if (tries_inc == 4'(MAX_TRIES)) begin
          // Masked draw is below 2*limit, so one subtraction lands in range.
          rsp_value_d    = folded;
          rsp_tries_d    = tries_inc;
          rsp_fallback_d = 1'b1;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      limit_q        <= '0;
      mask_q         <= '0;
      tries_q        <= '0;
      rsp_value_q    <= '0;
      rsp_tries_q    <= '0;
      rsp_fallback_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      limit_q        <= limit_d;
      mask_q         <= mask_d;
      tries_q        <= tries_d;
      rsp_value_q    <= rsp_value_d;
      rsp_tries_q    <= rsp_tries_d;
      rsp_fallback_q <= rsp_fallback_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == HOLD);
  assign rsp_value    = rsp_value_q;
  assign rsp_tries    = rsp_tries_q;
  assign rsp_fallback = rsp_fallback_q;

endmodule

// File: tb/tb_rand_range_gen.sv
// Directed bench for rand_range_gen: LFSR state is driven directly per draw cycle.
module tb_rand_range_gen;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  lfsr_state;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_limit;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_value;
  logic [3:0]   rsp_tries;
  logic         rsp_fallback;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rand_range_gen #(.W(W), .MAX_TRIES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .lfsr_state   (lfsr_state),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_limit    (req_limit),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_value    (rsp_value),
    .rsp_tries    (rsp_tries),
    .rsp_fallback (rsp_fallback)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [15:0] v, input logic [3:0] t,
                         input logic fb);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_value"}, 32'(rsp_value), 32'(v));
    chk({tag, "_tries"}, 32'(rsp_tries), 32'(t));
    chk({tag, "_fb"}, 32'(rsp_fallback), 32'(fb));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_value"}, 32'(rsp_value), 32'd0);
    chk({tag, "_tries"}, 32'(rsp_tries), 32'd0);
    chk({tag, "_fb"}, 32'(rsp_fallback), 32'd0);
  endtask

  // Accept cycle: request present for exactly one edge, then DRAW.
  task automatic accept(input logic [15:0] lim);
    req_valid = 1'b1;
    req_limit = lim;
    chk("accept_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("accept_busy", 32'(req_ready), 32'd0);
    chk("accept_novalid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    lfsr_state = 64'h0;
    req_valid  = 1'b0;
    req_limit  = '0;
    rsp_ready  = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_reset("por");

    // limit 10, first-try hit of 7
    accept(16'd10);
    lfsr_state = 64'hFFFF_FFFF_FFFF_0007;
    step();
    chk_rsp("hit1", 16'd7, 4'd1, 1'b0);
    release_rsp();

    // limit 10: 12 and 15 rejected, 3 accepted on third draw
    accept(16'd10);
    lfsr_state = 64'h000C;
    step();
    chk("rej1_valid", 32'(rsp_valid), 32'd0);
    lfsr_state = 64'h000F;
    step();
    chk("rej2_valid", 32'(rsp_valid), 32'd0);
    lfsr_state = 64'h0003;
    step();
    chk_rsp("hit3", 16'd3, 4'd3, 1'b0);
    release_rsp();

    // limit 10, every masked draw is 13: fallback after 8 tries -> 3
    accept(16'd10);
    lfsr_state = 64'h00FD;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("fb_wait_valid", 32'(rsp_valid), 32'd0);
    end
    step();
    chk_rsp("fallback", 16'd3, 4'd8, 1'b1);
    release_rsp();

    // limit 0 = full range
    accept(16'd0);
    lfsr_state = 64'h1234_5678_9ABC_BEEF;
    step();
    chk_rsp("full", 16'hBEEF, 4'd1, 1'b0);
    release_rsp();

    // limit 1: mask is zero, always 0
    accept(16'd1);
    lfsr_state = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk_rsp("lim1", 16'd0, 4'd1, 1'b0);
    release_rsp();

    // limit 16: mask 0xF, cand 15 is the largest in-range value
    accept(16'd16);
    lfsr_state = 64'h00FF;
    step();
    chk_rsp("lim16", 16'd15, 4'd1, 1'b0);
    release_rsp();

    // limit 17: mask widens to 0x1F, cand 16 in range
    accept(16'd17);
    lfsr_state = 64'h0030;
    step();
    chk_rsp("lim17", 16'd16, 4'd1, 1'b0);
    release_rsp();

    // backpressure: outputs stable for 5 cycles while LFSR keeps changing
    accept(16'd10);
    lfsr_state = 64'h0005;
    step();
    for (int i = 0; i < 5; i++) begin
      lfsr_state = 64'(i + 8);
      step();
      chk_rsp("hold", 16'd5, 4'd1, 1'b0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    release_rsp();
    accept(16'd10);
    lfsr_state = 64'h0002;
    step();
    chk_rsp("after_hold", 16'd2, 4'd1, 1'b0);
    release_rsp();

    // reset during second DRAW try
    accept(16'd10);
    lfsr_state = 64'h000C;
    step();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    lfsr_state = 64'h0001;
    step();
    reset = 1'b0;
    chk_reset("rst_draw");
    step();
    chk_reset("rst_draw_idle");

    // reset during HOLD
    accept(16'd10);
    lfsr_state = 64'h0004;
    step();
    chk_rsp("pre_rst_hold", 16'd4, 4'd1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset("rst_hold");

    // fresh request completes normally: 0x19 & 0xF = 9
    accept(16'd10);
    lfsr_state = 64'h0019;
    step();
    chk_rsp("fresh", 16'd9, 4'd1, 1'b0);
    release_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_range_gen.md
# rand_range_gen

Draws uniformly distributed random integers in a requested range [0, limit) from the free-running 64-bit LFSR state. Sits directly downstream of the 64-bit LFSR (XNOR taps 64/63/61/60, one shift per clk) and serves one request at a time over a valid/ready handshake. Uses mask-and-reject sampling with a bounded retry count, so there is no modulo bias within the retry budget and latency is always bounded.

## Interface
- W, 16: output value and limit width (2..32)
- MAX_TRIES, 8: draws attempted before the fallback path (1..15)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lfsr_state  in  64  LFSR output; advances every clk, sampled combinationally
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_limit  in  W  exclusive upper bound; 0 means full range 2^W
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer takes result
- rsp_value  out  W  result, always < limit (or any value if limit==0)
- rsp_tries  out  4  draws used (1..MAX_TRIES)
- rsp_fallback  out  1  result came from the fallback path

## Operation
- FSM states: IDLE, DRAW, HOLD.
- IDLE: req_ready=1. On req_valid&&req_ready, latch limit and mask = mask_for(limit), clear try count, go to DRAW.
- mask_for(limit): all ones from bit 0 up to the MSB of (limit-1); limit 0 -> all ones; limit 1 -> 0.
- DRAW, each cycle: cand = lfsr_state[W-1:0] & mask; tries+1.
  - limit==0, or cand < limit: register rsp_value=cand, rsp_tries, rsp_fallback=0, go to HOLD.
  - Else if tries == MAX_TRIES: register rsp_value = cand - limit (cand < 2*limit, so result < limit), rsp_fallback=1, go to HOLD.
  - Else stay in DRAW; the next cycle uses the advanced LFSR state.
- HOLD: rsp_valid=1, outputs stable. On rsp_ready, go to IDLE. No new request is accepted in the same cycle (req_ready=0 in HOLD).
- Arithmetic is unsigned, W bits; the comparison and subtraction do not widen.
- Reset, including mid-DRAW or mid-HOLD: state IDLE, req_ready=1, rsp_valid=0, rsp_value=0, rsp_tries=0, rsp_fallback=0, internal limit, mask and count cleared. An in-flight request is dropped.

## Timing
- Accept in cycle 0. First draw evaluates lfsr_state in cycle 1. rsp_valid is high from cycle 2 on a first-try hit.
- Latency is 1 + tries cycles from accept to rsp_valid. The maximum is 1 + MAX_TRIES.
- rsp_valid stays high with stable outputs until rsp_ready is sampled high. It deasserts the cycle after.
- Back-to-back requests have a minimum spacing of 3 cycles: accept, draw, HOLD with rsp_ready=1.
- req_ready is a function of state only. There is no combinational path from any input to req_ready or rsp_valid.

## Structure
- Package rand_pkg:
  - state enum rrg_state_t {IDLE, DRAW, HOLD}
  - function mask_for(limit) parameterised on width (or a W-generic automatic function)
  - constant LFSR_W=64
- Optional sub-module range_check (comb): takes cand, limit and mask. Outputs hit and folded value (cand - limit). It isolates the compare/subtract datapath for a standalone unit test.

## Test plan
- limit=10, W=16, lfsr_state[15:0]=0x0007 on the draw cycle -> rsp_valid in cycle 2, rsp_value=7, rsp_tries=1, rsp_fallback=0.
- limit=10, lfsr_state low bits over three draw cycles = 0x000C, 0x000F, 0x0003 (masked 12, 15, 3) -> rsp_value=3, rsp_tries=3, latency 4.
- limit=10, MAX_TRIES=8, every draw gives masked value 13 -> after 8 draws rsp_value=3, rsp_tries=8, rsp_fallback=1.
- limit=0 with lfsr_state[15:0]=0xBEEF -> rsp_value=0xBEEF, tries=1. Then limit=1 with any state -> rsp_value=0.
- Hold rsp_ready=0 for 5 cycles -> rsp_value, rsp_tries and rsp_valid stay stable and req_ready stays 0. Assert rsp_ready -> IDLE next cycle, and a new request is accepted one cycle later.
- Assert reset in DRAW (second try) and in HOLD -> next cycle outputs at reset values with req_ready=1. A fresh request then completes normally.
